mips_cpu_bus: RTL and testbench
===============================

// Module: mips_cpu_bus
// PURPOSE
//  Multicycle MIPS32 (big-endian, integer subset) CPU core with a single memory-mapped bus master port
//  used for both instruction fetch and data access. Top-level processor block of the design; the
//  testbench/SoC supplies memory on the bus. Runs from reset vector 0xBFC00000 until it jumps to
//  address 0, then halts and drops active.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  PC value loaded on reset
// PORTS
//  clk          in   1   single clock; all state changes on rising edge
//  reset        in   1   synchronous, active-high reset
//  active       out  1   1 while running; 0 once halted
//  register_v0  out  32  live value of GPR $2 (v0), for debug/checking
//  address      out  32  byte address of current bus access (word aligned)
//  write        out  1   bus write request
//  read         out  1   bus read request
//  waitrequest  in   1   slave stall; request held unchanged while 1
//  writedata    out  32  store data
//  byteenable   out  4   byte lanes; 4'b1111 for every LW/SW/fetch
//  readdata     in   32  read data, valid the cycle after a read is accepted
// BEHAVIOUR
//  Reset (sync, high): PC=RESET_VECTOR, nPC=PC+4, GPR[0..31]=0, HI=LO=0, state=FETCH, active=1,
//   read=write=0, byteenable=4'b1111. Reset mid-operation aborts any bus request at that edge.
//  Bus: request accepted on a rising edge where (read|write)=1 and waitrequest=0; until then
//   address/writedata/byteenable/read/write held stable. Never read and write together.
//  States: FETCH -> DECODE -> EXEC -> (MEM -> WB for LW | MEM for SW) -> FETCH; HALT terminal.
//   FETCH: if PC==0 go HALT (no bus access); else read=1, address=PC, wait for acceptance.
//   DECODE: latch readdata into IR; read registers rs/rt.
//   EXEC: ALU op; non-memory instrs write back rd/rt and advance PC; LW/SW compute rs+sext(imm).
//   MEM: LW read / SW write (writedata=rt) at computed address, wait for acceptance.
//   WB: LW writes readdata to rt. HALT: active=0, read=write=0, no further state change.
//  PC update: PC<=nPC; nPC<=nPC+4, or branch/jump target -> one delay slot, always executed.
//   Branch target = PC+4+(sext(imm)<<2). J/JAL target = {PC+4[31:28], instr_index, 2'b00}.
//   JAL: $31=PC+8. JALR: rd=PC+8, target=rs. JR: target=rs. Jump to 0 halts after delay slot.
//  Supported R: SLL SRL SRA JR JALR MFHI MTHI MFLO MTLO ADDU SUBU AND OR XOR NOR SLT SLTU.
//  Supported I/J: BEQ BNE ADDIU SLTI SLTIU ANDI ORI XORI (zero-ext) LUI LW SW J JAL.
//  Any other opcode/funct executes as NOP (PC advances). Arithmetic wraps mod 2^32, no traps.
//  Writes to $0 discarded; $0 reads 0. SLT/SLTI signed, SLTU/SLTIU unsigned, result 0/1.
//  register_v0 combinationally reflects GPR[2] (0 after reset).
// TESTING
//  Reset 1 cycle -> active=1 next cycle; first access read=1, address=0xBFC00000, byteenable=4'hF.
//  Program: lui $8,0xBFC0; jal 0xBFC00018; lw $2,0x2C($8); @0x18 mthi $31; jr $0; mfhi $2
//   -> active=0, v0=0xBFC0000C (lw result overwritten).
//  lui $2,0xFFFF; jr $0; nop -> halt, v0=0xFFFF0000.
//  waitrequest=1 for 3 cycles during fetch -> read/address held, PC unchanged; resumes after.
//  addiu $3,$0,0x55; sw $3,0x30($8); lw $2,0x30($8) -> write at 0xBFC00030 data 0x55, v0=0x55.
//  beq $0,$0,+2 with addiu $2,$2,1 in delay slot and at fall-through -> v0=1 (slot run, skip taken).

Source files
------------

// File: rtl/mips_cpu_bus.sv
// mips_cpu_bus: multicycle big-endian MIPS32 integer-subset core with one shared bus master port
//   clk/reset    rising-edge clock, synchronous active-high reset
//   active       high while running, low once the core has jumped to address 0 and halted
//   register_v0  live copy of GPR $2
//   address/read/write/writedata/byteenable  bus request, held stable while waitrequest is high
//   waitrequest  slave stall; readdata is valid the cycle after a read is accepted
module mips_cpu_bus #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t state;
    logic [31:0] regs [32];
    logic [31:0] pc, npc, ir, hi, lo, a, b;
    logic [31:0] res, tgt;
    logic [4:0]  dst;
    logic        we, hi_we, lo_we;
    logic [5:0]  op, fn;
    logic [4:0]  rt, rd, sh;
    logic [31:0] simm, zimm, pc4, pc8, btgt, jtgt;
    logic        is_lw, is_sw;
    assign op = ir[31:26];
    assign rt = ir[20:16];
    assign rd = ir[15:11];
    assign sh = ir[10:6];
    assign fn = ir[5:0];
    assign simm = {{16{ir[15]}}, ir[15:0]};
    assign zimm = {16'd0, ir[15:0]};
    assign pc4 = pc + 32'd4;
    assign pc8 = pc + 32'd8;
    assign btgt = pc4 + {simm[29:0], 2'b00};
    assign jtgt = {pc4[31:28], ir[25:0], 2'b00};
    assign is_lw = op == 6'h23;
    assign is_sw = op == 6'h2B;
    assign register_v0 = regs[2];
    // Default next-nPC is sequential; branches/jumps replace it, giving one delay slot.
    always_comb begin
        res = '0;
        dst = rd;
        we = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        tgt = npc + 32'd4;
        case (op)
            6'h00: begin
                we = 1'b1;
                case (fn)
                    6'h00: res = b << sh;
                    6'h02: res = b >> sh;
                    6'h03: res = $unsigned($signed(b) >>> sh);
                    6'h08: begin we = 1'b0; tgt = a; end
                    6'h09: begin res = pc8; tgt = a; end
                    6'h10: res = hi;
                    6'h11: begin we = 1'b0; hi_we = 1'b1; end
                    6'h12: res = lo;
                    6'h13: begin we = 1'b0; lo_we = 1'b1; end
                    6'h21: res = a + b;
                    6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = {31'd0, $signed(a) < $signed(b)};
                    6'h2B: res = {31'd0, a < b};
                    default: we = 1'b0;
                endcase
            end
            6'h02: tgt = jtgt;
            6'h03: begin we = 1'b1; dst = 5'd31; res = pc8; tgt = jtgt; end
            6'h04: tgt = (a == b) ? btgt : npc + 32'd4;
            6'h05: tgt = (a != b) ? btgt : npc + 32'd4;
            6'h09: begin we = 1'b1; dst = rt; res = a + simm; end
            6'h0A: begin we = 1'b1; dst = rt; res = {31'd0, $signed(a) < $signed(simm)}; end
            6'h0B: begin we = 1'b1; dst = rt; res = {31'd0, a < simm}; end
            6'h0C: begin we = 1'b1; dst = rt; res = a & zimm; end
            6'h0D: begin we = 1'b1; dst = rt; res = a | zimm; end
            6'h0E: begin we = 1'b1; dst = rt; res = a ^ zimm; end
            6'h0F: begin we = 1'b1; dst = rt; res = {ir[15:0], 16'd0}; end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc <= RESET_VECTOR;
            npc <= RESET_VECTOR + 32'd4;
            hi <= '0;
            lo <= '0;
            ir <= '0;
            a <= '0;
            b <= '0;
            active <= 1'b1;
            read <= 1'b0;
            write <= 1'b0;
            address <= '0;
            writedata <= '0;
            byteenable <= 4'b1111;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (pc == 32'd0) begin
                        state <= HALT;
                        active <= 1'b0;
                    end else if (!read) begin
                        read <= 1'b1;
                        address <= pc;
                    end else if (!waitrequest) begin
                        read <= 1'b0;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    // Operands come straight from the fetched word, saving a cycle.
                    ir <= readdata;
                    a <= regs[readdata[25:21]];
                    b <= regs[readdata[20:16]];
                    state <= EXEC;
                end
                EXEC: begin
                    if (is_lw || is_sw) begin
                        address <= a + simm;
                        writedata <= b;
                        read <= is_lw;
                        write <= is_sw;
                        state <= MEM;
                    end else begin
                        if (we && dst != 5'd0) regs[dst] <= res;
                        if (hi_we) hi <= a;
                        if (lo_we) lo <= a;
                        state <= FETCH;
                    end
                    pc <= npc;
                    npc <= tgt;
                end
                MEM: begin
                    if (!waitrequest) begin
                        read <= 1'b0;
                        write <= 1'b0;
                        state <= write ? FETCH : WB;
                    end
                end
                WB: begin
                    if (rt != 5'd0) regs[rt] <= readdata;
                    state <= FETCH;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_cpu_bus.sv
// tb_mips_cpu_bus: directed programs on a small bus memory, checking v0, bus traffic and stored results
module tb_mips_cpu_bus;
    logic        clk, reset, active, write, read, waitrequest;
    logic [31:0] register_v0, address, writedata, readdata;
    logic [3:0]  byteenable;
    logic [31:0] mem [64];
    logic [31:0] off, last_addr, last_data;
    int          wr_cnt, errors, checks;

    mips_cpu_bus dut (
        .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
        .address(address), .write(write), .read(read), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign off = address - 32'hBFC00000;

    always @(posedge clk) begin
        if (!reset && !waitrequest) begin
            if (read) readdata <= mem[off[7:2]];
            if (write) begin
                mem[off[7:2]] = writedata;
                last_addr = address;
                last_data = writedata;
                wr_cnt = wr_cnt + 1;
            end
        end
    end

    function automatic logic [31:0] r_ins(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction
    function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction
    function automatic logic [31:0] j_ins(int op, int idx);
        return {op[5:0], idx[25:0]};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        wr_cnt = 0;
        last_addr = '0;
        last_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to_halt(string tag);
        int n = 0;
        while (active === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, active}, 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        waitrequest = 1'b1;
        readdata = '0;
        // lui $2,0xFFFF; jr $0; nop  with a stalled first fetch
        clear_mem();
        mem[0] = i_ins('h0F, 0, 2, 'hFFFF);
        mem[1] = r_ins(0, 0, 0, 0, 'h08);
        mem[2] = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_active", {31'd0, active}, 32'd1);
        chk("rst_read", {31'd0, read}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_be", {28'd0, byteenable}, 32'hF);
        chk("rst_v0", register_v0, 32'd0);
        reset = 1'b0;
        for (int n = 0; n < 10 && read !== 1'b1; n++) @(negedge clk);
        chk("fetch_read", {31'd0, read}, 32'd1);
        chk("fetch_addr", address, 32'hBFC00000);
        chk("fetch_be", {28'd0, byteenable}, 32'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_read", {31'd0, read}, 32'd1);
            chk("stall_addr", address, 32'hBFC00000);
        end
        waitrequest = 1'b0;
        run_to_halt("halt_lui");
        chk("v0_lui", register_v0, 32'hFFFF0000);
        chk("halt_read", {30'd0, read, write}, 32'd0);

        // jal with a lw in the delay slot, overwritten by mfhi of the link value
        clear_mem();
        mem[0] = i_ins('h0F, 0, 8, 'hBFC0);
        mem[1] = j_ins('h03, 'h3F00006);
        mem[2] = i_ins('h23, 8, 2, 'h2C);
        mem[6] = r_ins(31, 0, 0, 0, 'h11);
        mem[7] = r_ins(0, 0, 0, 0, 'h08);
        mem[8] = r_ins(0, 0, 2, 0, 'h10);
        mem[11] = 32'h12345678;
        do_reset();
        run_to_halt("halt_jal");
        chk("v0_jal", register_v0, 32'hBFC0000C);

        // store then load back through v0
        clear_mem();
        mem[0] = i_ins('h0F, 0, 8, 'hBFC0);
        mem[1] = i_ins('h09, 0, 3, 'h55);
        mem[2] = i_ins('h2B, 8, 3, 'h30);
        mem[3] = i_ins('h23, 8, 2, 'h30);
        mem[4] = r_ins(0, 0, 0, 0, 'h08);
        do_reset();
        run_to_halt("halt_sw");
        chk("sw_count", wr_cnt, 32'd1);
        chk("sw_addr", last_addr, 32'hBFC00030);
        chk("sw_data", last_data, 32'h55);
        chk("v0_lw", register_v0, 32'h55);

        // taken branch: delay slot runs, fall-through skipped
        clear_mem();
        mem[0] = i_ins('h04, 0, 0, 2);
        mem[1] = i_ins('h09, 2, 2, 1);
        mem[2] = i_ins('h09, 2, 2, 1);
        mem[3] = r_ins(0, 0, 0, 0, 'h08);
        do_reset();
        run_to_halt("halt_beq");
        chk("v0_beq", register_v0, 32'd1);

        // ALU mix, results dumped to memory
        clear_mem();
        mem[0]  = i_ins('h0F, 0, 8, 'hBFC0);
        mem[1]  = i_ins('h09, 0, 4, -5);
        mem[2]  = i_ins('h09, 0, 5, 3);
        mem[3]  = r_ins(4, 5, 6, 0, 'h2A);
        mem[4]  = r_ins(4, 5, 7, 0, 'h2B);
        mem[5]  = r_ins(0, 4, 9, 1, 'h03);
        mem[6]  = r_ins(0, 4, 10, 28, 'h02);
        mem[7]  = r_ins(5, 0, 11, 0, 'h27);
        mem[8]  = i_ins('h0E, 5, 12, 'hFFFF);
        mem[9]  = r_ins(5, 4, 13, 0, 'h23);
        mem[10] = i_ins('h2B, 8, 6, 'h80);
        mem[11] = i_ins('h2B, 8, 7, 'h84);
        mem[12] = i_ins('h2B, 8, 9, 'h88);
        mem[13] = i_ins('h2B, 8, 10, 'h8C);
        mem[14] = i_ins('h2B, 8, 11, 'h90);
        mem[15] = i_ins('h2B, 8, 12, 'h94);
        mem[16] = i_ins('h2B, 8, 13, 'h98);
        mem[17] = r_ins(13, 0, 0, 0, 'h13);
        mem[18] = r_ins(0, 0, 2, 0, 'h12);
        mem[19] = r_ins(0, 0, 0, 0, 'h08);
        mem[20] = i_ins('h09, 2, 2, 1);
        mem[32] = 32'hDEADBEEF;
        mem[33] = 32'hDEADBEEF;
        do_reset();
        run_to_halt("halt_alu");
        chk("slt", mem[32], 32'd1);
        chk("sltu", mem[33], 32'd0);
        chk("sra", mem[34], 32'hFFFFFFFD);
        chk("srl", mem[35], 32'h0000000F);
        chk("nor", mem[36], 32'hFFFFFFFC);
        chk("xori", mem[37], 32'h0000FFFC);
        chk("subu", mem[38], 32'd8);
        chk("v0_alu", register_v0, 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
